// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable program memory, FETCH/EXEC sequencing,
// halt detection and a saturating retired-instruction counter for the core.
module instr_fetch_unit #(
    parameter int              IW        = 21,
    parameter int              AW        = 8,
    parameter logic [IW-1:0]   NOP_WORD  = 21'h000000,
    parameter logic [IW-1:0]   HALT_WORD = 21'h1FFFFF,
    parameter int              CW        = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          PROG_EN,
    input  logic          LD_VALID,
    output logic          LD_READY,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [IW-1:0] LD_DATA,
    input  logic          START,
    input  logic          STOP,
    input  logic [AW-1:0] ADDR_IN,
    output logic [IW-1:0] INS,
    output logic          CORE_CE,
    output logic [2:0]    STATE,
    output logic          HALTED,
    output logic [CW-1:0] RETIRED
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_LOAD  = 3'b001,
        S_FETCH = 3'b010,
        S_EXEC  = 3'b011,
        S_HALT  = 3'b100
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] ir;
    logic [IW-1:0] ir_next;
    logic [IW-1:0] rd_word;
    logic          fetch_halt;
    logic          ld_ready_q;
    logic          ld_fire;
    logic [CW-1:0] retired_q;

    // Load handshake: a word transfers on any rising edge where LD_VALID and
    // LD_READY are both high; LD_READY is registered and only ever high in LOAD.
    assign ld_fire    = (state == S_LOAD) && LD_VALID && ld_ready_q;
    assign rd_word    = mem[ADDR_IN];
    assign fetch_halt = (rd_word == HALT_WORD);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (PROG_EN) begin
                    next_state = S_LOAD;
                end else if (START) begin
                    next_state = S_FETCH;
                end
            end
            S_LOAD: begin
                if (!PROG_EN) begin
                    next_state = S_IDLE;
                end
            end
            S_FETCH: begin
                if (STOP) begin
                    next_state = S_IDLE;
                end else if (fetch_halt) begin
                    next_state = S_HALT;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                next_state = STOP ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                if (STOP) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // IR keeps the executed word through the following FETCH; every path
    // out of the run loop parks it on NOP_WORD.
    always_comb begin
        ir_next = ir;
        case (state)
            S_FETCH: ir_next = (STOP || fetch_halt) ? NOP_WORD : rd_word;
            S_EXEC:  ir_next = STOP ? NOP_WORD : ir;
            default: ir_next = NOP_WORD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir         <= NOP_WORD;
            ld_ready_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            ir         <= ir_next;
            ld_ready_q <= (state == S_LOAD) && (next_state == S_LOAD);
            if ((state == S_EXEC) && (retired_q != {CW{1'b1}})) begin
                retired_q <= retired_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Program memory is deliberately not reset so a loaded program survives RST_N.
    always_ff @(posedge CLK) begin
        if (ld_fire) begin
            mem[LD_ADDR] <= LD_DATA;
        end
    end

    assign INS      = ir;
    assign CORE_CE  = (state == S_EXEC);
    assign STATE    = state;
    assign HALTED   = (state == S_HALT);
    assign LD_READY = ld_ready_q;
    assign RETIRED  = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: a main DUT plus a CW=4 copy
// sharing the same stimulus to exercise counter saturation.
module tb_instr_fetch_unit;

    localparam int IW = 21;
    localparam int AW = 8;
    localparam int CW = 16;
    localparam logic [IW-1:0] NOP_W  = 21'h000000;
    localparam logic [IW-1:0] HALT_W = 21'h1FFFFF;
    localparam logic [IW-1:0] W0     = 21'h0C000A;
    localparam logic [IW-1:0] W1     = 21'h0C0814;
    localparam logic [IW-1:0] W3     = 21'h012345;
    localparam logic [IW-1:0] W255   = 21'h0ABCDE;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          PROG_EN;
    logic          LD_VALID;
    logic          LD_READY;
    logic [AW-1:0] LD_ADDR;
    logic [IW-1:0] LD_DATA;
    logic          START;
    logic          STOP;
    logic [AW-1:0] ADDR_IN;
    logic [IW-1:0] INS;
    logic          CORE_CE;
    logic [2:0]    STATE;
    logic          HALTED;
    logic [CW-1:0] RETIRED;

    logic          sat_ld_ready;
    logic [IW-1:0] sat_ins;
    logic          sat_core_ce;
    logic [2:0]    sat_state;
    logic          sat_halted;
    logic [3:0]    sat_retired;

    logic [IW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            exp_retired = 0;

    instr_fetch_unit dut (
        .CLK(CLK), .RST_N(RST_N), .PROG_EN(PROG_EN), .LD_VALID(LD_VALID),
        .LD_READY(LD_READY), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .START(START), .STOP(STOP), .ADDR_IN(ADDR_IN), .INS(INS),
        .CORE_CE(CORE_CE), .STATE(STATE), .HALTED(HALTED), .RETIRED(RETIRED)
    );

    instr_fetch_unit #(.CW(4)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .PROG_EN(PROG_EN), .LD_VALID(LD_VALID),
        .LD_READY(sat_ld_ready), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .START(START), .STOP(STOP), .ADDR_IN(ADDR_IN), .INS(sat_ins),
        .CORE_CE(sat_core_ce), .STATE(sat_state), .HALTED(sat_halted),
        .RETIRED(sat_retired)
    );

    // Clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every CORE_CE cycle presents one instruction to the core.
    always @(negedge CLK) begin : monitor
        logic [IW-1:0] w;
        if (CORE_CE === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL ins_unexpected: got %0h expected none", INS);
            end else begin
                w = exp_q.pop_front();
                chk("ins", INS, w);
            end
        end
    end

    // Driver tasks
    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
        LD_ADDR = a;
        LD_DATA = d;
        step();
    endtask

    task automatic start_run;
        START = 1'b1;
        step();
        START = 1'b0;
        chk("start_fetch_state", STATE, 3'b010);
        chk("start_fetch_ce", CORE_CE, 1'b0);
    endtask

    task automatic run_instr(input logic [AW-1:0] a, input logic [IW-1:0] w);
        ADDR_IN = a;
        exp_q.push_back(w);
        step();
        chk("exec_state", STATE, 3'b011);
        chk("exec_ce", CORE_CE, 1'b1);
        chk("exec_ld_ready", LD_READY, 1'b0);
        step();
        exp_retired++;
        chk("fetch_state", STATE, 3'b010);
        chk("fetch_ce", CORE_CE, 1'b0);
        chk("retired", RETIRED, exp_retired);
        chk("retired_sat", sat_retired, (exp_retired > 15) ? 15 : exp_retired);
    endtask

    initial begin
        int bad_ce;
        RST_N = 1'b0; PROG_EN = 1'b0; LD_VALID = 1'b0; LD_ADDR = '0;
        LD_DATA = '0; START = 1'b0; STOP = 1'b0; ADDR_IN = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_state", STATE, 3'b000);
        chk("rst_ins", INS, NOP_W);
        chk("rst_ce", CORE_CE, 1'b0);
        chk("rst_ld_ready", LD_READY, 1'b0);
        chk("rst_halted", HALTED, 1'b0);
        chk("rst_retired", RETIRED, 0);
        RST_N = 1'b1;
        step();
        chk("idle_state", STATE, 3'b000);

        // Program load; LD_READY rises only in the second LOAD cycle
        PROG_EN = 1'b1;
        step();
        chk("load_state", STATE, 3'b001);
        chk("load_ready_first", LD_READY, 1'b0);
        LD_VALID = 1'b1; LD_ADDR = 8'd0; LD_DATA = W0;
        step();
        chk("load_ready_second", LD_READY, 1'b1);
        step();
        load_word(8'd1, W1);
        load_word(8'd2, HALT_W);
        load_word(8'd3, W3);
        load_word(8'd255, W255);
        LD_VALID = 1'b0; PROG_EN = 1'b0;
        step();
        chk("load_exit_state", STATE, 3'b000);
        chk("load_exit_ready", LD_READY, 1'b0);

        // Held address 0: CE pattern 0,1,0,1 and two retirements
        ADDR_IN = 8'd0;
        start_run();
        run_instr(8'd0, W0);
        run_instr(8'd0, W0);
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk("stop_fetch_state", STATE, 3'b000);
        chk("stop_fetch_ins", INS, NOP_W);

        // Core steps 0->1->2; mem[2] halts
        ADDR_IN = 8'd0;
        start_run();
        run_instr(8'd0, W0);
        run_instr(8'd1, W1);
        ADDR_IN = 8'd2;
        step();
        chk("halt_state", STATE, 3'b100);
        chk("halt_flag", HALTED, 1'b1);
        chk("halt_ins", INS, NOP_W);
        START = 1'b1; PROG_EN = 1'b1;
        bad_ce = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (CORE_CE !== 1'b0 || STATE !== 3'b100) bad_ce++;
        end
        chk("halt_hold_cycles", bad_ce, 0);
        chk("halt_retired_frozen", RETIRED, exp_retired);
        START = 1'b0; PROG_EN = 1'b0; STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk("halt_stop_state", STATE, 3'b000);
        chk("halt_stop_flag", HALTED, 1'b0);

        // PROG_EN beats START in IDLE
        PROG_EN = 1'b1; START = 1'b1;
        step();
        chk("prio_state", STATE, 3'b001);
        START = 1'b0; PROG_EN = 1'b0;
        step();
        chk("prio_exit_state", STATE, 3'b000);

        // Stray load requests while running must not write
        LD_VALID = 1'b1; LD_ADDR = 8'd0; LD_DATA = HALT_W;
        ADDR_IN = 8'd0;
        start_run();
        chk("run_ld_ready", LD_READY, 1'b0);
        run_instr(8'd0, W0);
        ADDR_IN = 8'd1;
        exp_q.push_back(W1);
        step();
        STOP = 1'b1;
        chk("stop_exec_ce", CORE_CE, 1'b1);
        step();
        STOP = 1'b0;
        exp_retired++;
        chk("stop_exec_state", STATE, 3'b000);
        chk("stop_exec_ins", INS, NOP_W);
        chk("stop_exec_retired", RETIRED, exp_retired);
        LD_VALID = 1'b0;

        // Asynchronous reset in the middle of EXEC
        ADDR_IN = 8'd0;
        start_run();
        exp_q.push_back(W0);
        step();
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("amid_ce", CORE_CE, 1'b0);
        chk("amid_state", STATE, 3'b000);
        chk("amid_retired", RETIRED, 0);
        chk("amid_ins", INS, NOP_W);
        exp_retired = 0;
        step();
        RST_N = 1'b1;
        step();
        start_run();
        run_instr(8'd0, W0);
        STOP = 1'b1;
        step();
        STOP = 1'b0;

        // Address wrap 255 -> 0, then saturate the CW=4 counter
        start_run();
        run_instr(8'd255, W255);
        run_instr(8'd0, W0);
        run_instr(8'd1, W1);
        for (int i = 0; i < 16; i++) begin
            run_instr(8'd3, W3);
        end
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk("final_state", STATE, 3'b000);
        chk("final_sat_retired", sat_retired, 4'd15);

        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
